// File: rtl/ldr_pkg.sv
// Shared types and constants for the ioctl -> LOADER bridge.
package ldr_pkg;

  localparam int LDR_AW          = 19;
  localparam int LDR_WAIT_MARGIN = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ldr_state_t;

  typedef struct packed {
    logic [LDR_AW-1:0] addr;
    logic [7:0]        data;
  } ldr_entry_t;

endpackage

// File: rtl/ldr_fifo.sv
// Small synchronous FIFO of loader entries; pointers carry one extra wrap bit.
module ldr_fifo
  import ldr_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_sys,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  ldr_entry_t               din,
  output ldr_entry_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH) + 1;

  ldr_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == PW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a push into a full FIFO still lands when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PW-2:0]];

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[PW-2:0]] <= din;
  end

endmodule

// File: rtl/ioctl_loader_bridge.sv
// Buffers the HPS ioctl byte stream and replays it on the LOADER_* WR/ACK port.
// Define LDR_CHECKSUM_EN to add the ldr_sum output (sum of ACKed bytes).
//   state | meaning
//   IDLE  | waiting for ioctl_download to rise
//   LOAD  | download active, bytes captured and replayed
//   DRAIN | download ended, flushing remaining entries
//   DONE  | everything written, LOADER_DONE held until reset
module ioctl_loader_bridge
  import ldr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 19
) (
  input  logic          clk_sys,
  input  logic          rstn,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          LOADER_OE,
  output logic [AW-1:0] LOADER_ADR,
  output logic [7:0]    LOADER_WDAT,
  output logic          LOADER_WR,
  input  logic          LOADER_ACK,
  output logic          LOADER_DONE,
  output logic          ldr_overflow
`ifdef LDR_CHECKSUM_EN
  ,
  output logic [15:0]   ldr_sum
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ldr_state_t    state;
  logic          dl_q;
  logic          ack_q;
  logic          dl_rise;
  logic          dl_fall;
  logic          ack_rise;
  logic          active;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;
  ldr_entry_t    wr_entry;
  ldr_entry_t    head;

  assign dl_rise  = ioctl_download && !dl_q;
  assign dl_fall  = !ioctl_download && dl_q;
  assign ack_rise = LOADER_ACK && !ack_q;
  assign active   = (state == LOAD) || (state == DRAIN);
  assign push     = ioctl_wr && active;
  assign pop      = active && !LOADER_WR && !fifo_empty;
  assign push_ok  = push && (!fifo_full || pop);
  assign wr_entry = '{addr: LDR_AW'(ioctl_addr), data: ioctl_dout};
  // wait tracks the occupancy the FIFO will have after this edge
  assign count_nxt = fifo_count + CW'(push_ok) - CW'(pop);

  ldr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .rstn    (rstn),
    .push    (push),
    .pop     (pop),
    .din     (wr_entry),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      dl_q         <= 1'b0;
      ack_q        <= 1'b0;
      ioctl_wait   <= 1'b0;
      LOADER_OE    <= 1'b0;
      LOADER_ADR   <= '0;
      LOADER_WDAT  <= '0;
      LOADER_WR    <= 1'b0;
      LOADER_DONE  <= 1'b0;
      ldr_overflow <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      ack_q      <= LOADER_ACK;
      ioctl_wait <= (count_nxt >= CW'(DEPTH - LDR_WAIT_MARGIN));
      if (push && fifo_full && !pop) ldr_overflow <= 1'b1;

      if (pop) begin
        LOADER_WR   <= 1'b1;
        LOADER_ADR  <= AW'(head.addr);
        LOADER_WDAT <= head.data;
      end else if (LOADER_WR && ack_rise) begin
        LOADER_WR <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (dl_rise) begin
            state     <= LOAD;
            LOADER_OE <= 1'b1;
          end
        end
        LOAD: begin
          if (dl_fall) state <= DRAIN;
        end
        DRAIN: begin
          if (dl_rise) begin
            state <= LOAD;
          end else if (fifo_empty && !push && !LOADER_WR) begin
            state       <= DONE;
            LOADER_OE   <= 1'b0;
            LOADER_DONE <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LDR_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      ldr_sum <= '0;
    end else if (LOADER_WR && ack_rise && (state != DONE)) begin
      ldr_sum <= ldr_sum + 16'(LOADER_WDAT);
    end
  end
`endif

endmodule

// File: tb/tb_ioctl_loader_bridge.sv
// Self-checking bench for ioctl_loader_bridge: scripted scenarios plus a randomized stream.
module tb_ioctl_loader_bridge;

  localparam int DEPTH = 8;
  localparam int AW    = 19;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk_sys = 1'b0;
  logic          rstn = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wait;
  logic          LOADER_OE;
  logic [AW-1:0] LOADER_ADR;
  logic [7:0]    LOADER_WDAT;
  logic          LOADER_WR;
  logic          LOADER_ACK = 1'b0;
  logic          LOADER_DONE;
  logic          ldr_overflow;
`ifdef LDR_CHECKSUM_EN
  logic [15:0]   ldr_sum;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_sys = ~clk_sys;

  ioctl_loader_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys        (clk_sys),
    .rstn           (rstn),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .LOADER_OE      (LOADER_OE),
    .LOADER_ADR     (LOADER_ADR),
    .LOADER_WDAT    (LOADER_WDAT),
    .LOADER_WR      (LOADER_WR),
    .LOADER_ACK     (LOADER_ACK),
    .LOADER_DONE    (LOADER_DONE),
    .ldr_overflow   (ldr_overflow)
`ifdef LDR_CHECKSUM_EN
    ,
    .ldr_sum        (ldr_sum)
`endif
  );

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    LOADER_ACK = 1'b0;
    repeat (2) tick;
    rstn = 1'b1;
    tick;
  endtask

  task automatic push_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick;
    ioctl_wr = 1'b0;
  endtask

  // Core-side handshake: wait for WR, hold ACK off for dly cycles, then raise it.
  task automatic serve_one(input int dly, output logic [AW-1:0] a, output logic [7:0] d,
                           output logic got, output logic hs_ok);
    got = 1'b0;
    hs_ok = 1'b1;
    a = '0;
    d = '0;
    for (int i = 0; i < 200; i++) begin
      if (LOADER_WR === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick;
    end
    if (got) begin
      a = LOADER_ADR;
      d = LOADER_WDAT;
      repeat (dly) begin
        tick;
        if (LOADER_WR !== 1'b1 || LOADER_ADR !== a || LOADER_WDAT !== d) hs_ok = 1'b0;
      end
      LOADER_ACK = 1'b1;
      tick;
      if (LOADER_WR !== 1'b0) hs_ok = 1'b0;
      LOADER_ACK = 1'b0;
    end
  endtask

  task automatic wait_done;
    for (int i = 0; i < 20 && LOADER_DONE !== 1'b1; i++) tick;
  endtask

  task automatic test_reset;
    logic [AW-1:0] a;
    logic [7:0] d;
    logic got, hs;
    do_reset;
    n_checks++; if ({ioctl_wait, LOADER_OE, LOADER_WR, LOADER_DONE, ldr_overflow} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000", {ioctl_wait, LOADER_OE, LOADER_WR, LOADER_DONE, ldr_overflow}); else n_pass++;
    n_checks++; if ({LOADER_ADR, LOADER_WDAT} !== '0)
      $display("FAIL reset_adr_wdat got=%h/%h exp=0/0", LOADER_ADR, LOADER_WDAT); else n_pass++;
    push_byte(19'h00055, 8'h5A);
    push_byte(19'h00056, 8'h5B);
    repeat (3) tick;
    n_checks++; if ({LOADER_WR, LOADER_OE} !== 2'b00)
      $display("FAIL idle_ignores_wr got=%b exp=00", {LOADER_WR, LOADER_OE}); else n_pass++;
    ioctl_download = 1'b1;
    tick;
    push_byte(19'h00123, 8'h77);
    ioctl_download = 1'b0;
    serve_one(1, a, d, got, hs);
    n_checks++; if ({got, hs, a, d} !== {2'b11, 19'h00123, 8'h77})
      $display("FAIL idle_first_entry got=%b%b %h/%h exp=11 00123/77", got, hs, a, d); else n_pass++;
  endtask

  task automatic test_basic;
    logic [AW-1:0] a;
    logic [7:0] d;
    logic got, hs;
    do_reset;
    ioctl_download = 1'b1;
    tick;
    n_checks++; if (LOADER_OE !== 1'b1) $display("FAIL basic_oe_load got=%b exp=1", LOADER_OE); else n_pass++;
    for (int i = 0; i < 4; i++) push_byte(AW'(i), 8'hA0 + 8'(i));
    ioctl_download = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve_one(3, a, d, got, hs);
      n_checks++; if ({got, hs, a, d} !== {2'b11, AW'(i), 8'hA0 + 8'(i)})
        $display("FAIL basic_write%0d got=%b%b %h/%h exp=11 %h/%h", i, got, hs, a, d, AW'(i), 8'hA0 + 8'(i));
      else n_pass++;
    end
    n_checks++; if (LOADER_DONE !== 1'b0) $display("FAIL basic_done_early got=%b exp=0", LOADER_DONE); else n_pass++;
    tick;
    n_checks++; if ({LOADER_DONE, LOADER_OE} !== 2'b10)
      $display("FAIL basic_done_oe got=%b exp=10", {LOADER_DONE, LOADER_OE}); else n_pass++;
  endtask

  task automatic test_backpressure;
    wr_t exp[$];
    int sent;
    logic saw_wait;
    do_reset;
    for (int i = 0; i < 10; i++) exp.push_back({AW'($urandom), 8'($urandom)});
    ioctl_download = 1'b1;
    tick;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (sent < 10 && ioctl_wait === 1'b0) begin
        ioctl_wr = 1'b1; ioctl_addr = exp[sent].addr; ioctl_dout = exp[sent].data; sent++;
      end else ioctl_wr = 1'b0;
      tick;
    end
    ioctl_wr = 1'b0;
    saw_wait = ioctl_wait;
    n_checks++; if (sent != DEPTH - 1) $display("FAIL bp_stall_point got=%0d exp=%0d", sent, DEPTH - 1); else n_pass++;
    n_checks++; if ({saw_wait, ldr_overflow} !== 2'b10)
      $display("FAIL bp_wait_ovf got=%b exp=10", {saw_wait, ldr_overflow}); else n_pass++;
    fork
      begin
        for (int c = 0; c < 2000 && sent < 10; c++) begin
          if (ioctl_wait === 1'b0) begin
            ioctl_wr = 1'b1; ioctl_addr = exp[sent].addr; ioctl_dout = exp[sent].data; sent++;
          end else ioctl_wr = 1'b0;
          tick;
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
      end
      begin
        logic [AW-1:0] a;
        logic [7:0] d;
        logic got, hs;
        for (int k = 0; k < 10; k++) begin
          serve_one(1, a, d, got, hs);
          n_checks++; if ({got, hs, a, d} !== {2'b11, exp[k]})
            $display("FAIL bp_write%0d got=%b%b %h/%h exp=11 %h/%h", k, got, hs, a, d, exp[k].addr, exp[k].data);
          else n_pass++;
        end
      end
    join
    wait_done;
    n_checks++; if ({LOADER_DONE, ldr_overflow} !== 2'b10)
      $display("FAIL bp_end got=%b exp=10", {LOADER_DONE, ldr_overflow}); else n_pass++;
  endtask

  task automatic test_overflow;
    wr_t exp[$];
    logic [AW-1:0] a;
    logic [7:0] d;
    logic got, hs;
    do_reset;
    for (int i = 0; i < 10; i++) exp.push_back({AW'($urandom), 8'($urandom)});
    ioctl_download = 1'b1;
    tick;
    for (int i = 0; i < 9; i++) push_byte(exp[i].addr, exp[i].data);
    n_checks++; if (ldr_overflow !== 1'b0) $display("FAIL ovf_at_full got=%b exp=0", ldr_overflow); else n_pass++;
    push_byte(exp[9].addr, exp[9].data);
    n_checks++; if (ldr_overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", ldr_overflow); else n_pass++;
    ioctl_download = 1'b0;
    // engine register plus a full FIFO hold DEPTH+1 bytes; the last one is gone
    for (int k = 0; k < DEPTH + 1; k++) begin
      serve_one(0, a, d, got, hs);
      n_checks++; if ({got, hs, a, d} !== {2'b11, exp[k]})
        $display("FAIL ovf_write%0d got=%b%b %h/%h exp=11 %h/%h", k, got, hs, a, d, exp[k].addr, exp[k].data);
      else n_pass++;
    end
    wait_done;
    n_checks++; if ({LOADER_DONE, ldr_overflow, LOADER_WR} !== 3'b110)
      $display("FAIL ovf_sticky got=%b exp=110", {LOADER_DONE, ldr_overflow, LOADER_WR}); else n_pass++;
  endtask

  task automatic test_drain;
    wr_t exp[$];
    logic [AW-1:0] a;
    logic [7:0] d;
    logic got, hs;
    do_reset;
    for (int i = 0; i < 3; i++) exp.push_back({AW'($urandom), 8'($urandom)});
    ioctl_download = 1'b1;
    tick;
    push_byte(exp[0].addr, exp[0].data);
    push_byte(exp[1].addr, exp[1].data);
    ioctl_download = 1'b0;
    push_byte(exp[2].addr, exp[2].data);
    n_checks++; if ({LOADER_OE, LOADER_DONE} !== 2'b10)
      $display("FAIL drain_oe got=%b exp=10", {LOADER_OE, LOADER_DONE}); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      serve_one(2, a, d, got, hs);
      n_checks++; if ({got, hs, a, d} !== {2'b11, exp[k]})
        $display("FAIL drain_write%0d got=%b%b %h/%h exp=11 %h/%h", k, got, hs, a, d, exp[k].addr, exp[k].data);
      else n_pass++;
      if (k < 2) begin
        n_checks++; if ({LOADER_OE, LOADER_DONE} !== 2'b10)
          $display("FAIL drain_pending%0d got=%b exp=10", k, {LOADER_OE, LOADER_DONE}); else n_pass++;
      end
    end
    tick;
    n_checks++; if ({LOADER_DONE, LOADER_OE} !== 2'b10)
      $display("FAIL drain_done got=%b exp=10", {LOADER_DONE, LOADER_OE}); else n_pass++;
    ioctl_download = 1'b1;
    tick;
    push_byte(19'h00321, 8'h99);
    ioctl_download = 1'b0;
    repeat (4) tick;
    n_checks++; if ({LOADER_DONE, LOADER_OE, LOADER_WR} !== 3'b100)
      $display("FAIL done_terminal got=%b exp=100", {LOADER_DONE, LOADER_OE, LOADER_WR}); else n_pass++;
    #3 rstn = 1'b0;
    #1;
    n_checks++; if (LOADER_DONE !== 1'b0) $display("FAIL done_async_clear got=%b exp=0", LOADER_DONE); else n_pass++;
    tick;
    rstn = 1'b1;
  endtask

  task automatic test_reset_mid;
    wr_t exp[$];
    logic [AW-1:0] a;
    logic [7:0] d;
    logic got, hs;
    do_reset;
    ioctl_download = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) push_byte(AW'($urandom) | AW'(1), 8'($urandom) | 8'h01);
    for (int i = 0; i < 10 && LOADER_WR !== 1'b1; i++) tick;
    #3 rstn = 1'b0;
    ioctl_download = 1'b0;
    #1;
    n_checks++; if ({LOADER_WR, LOADER_OE, ioctl_wait, LOADER_DONE, LOADER_ADR, LOADER_WDAT} !== '0)
      $display("FAIL rst_mid_async got=%b%b%b%b %h/%h exp=0000 0/0", LOADER_WR, LOADER_OE, ioctl_wait,
               LOADER_DONE, LOADER_ADR, LOADER_WDAT); else n_pass++;
    tick;
    rstn = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) exp.push_back({AW'($urandom), 8'($urandom)});
    ioctl_download = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) push_byte(exp[i].addr, exp[i].data);
    ioctl_download = 1'b0;
    for (int k = 0; k < 2; k++) begin
      serve_one(1, a, d, got, hs);
      n_checks++; if ({got, hs, a, d} !== {2'b11, exp[k]})
        $display("FAIL rst_reload%0d got=%b%b %h/%h exp=11 %h/%h", k, got, hs, a, d, exp[k].addr, exp[k].data);
      else n_pass++;
    end
    wait_done;
    n_checks++; if (LOADER_DONE !== 1'b1) $display("FAIL rst_reload_done got=%b exp=1", LOADER_DONE); else n_pass++;
  endtask

  task automatic test_random_stream;
    wr_t exp[$];
    int n;
    int sent;
    do_reset;
    n = $urandom_range(5, 24);
    for (int i = 0; i < n; i++) exp.push_back({AW'($urandom), 8'($urandom)});
    ioctl_download = 1'b1;
    tick;
    sent = 0;
    fork
      begin
        for (int c = 0; c < 3000 && sent < n; c++) begin
          if (ioctl_wait === 1'b0 && $urandom_range(0, 3) != 0) begin
            ioctl_wr = 1'b1; ioctl_addr = exp[sent].addr; ioctl_dout = exp[sent].data; sent++;
          end else ioctl_wr = 1'b0;
          tick;
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
      end
      begin
        logic [AW-1:0] a;
        logic [7:0] d;
        logic got, hs;
        for (int k = 0; k < n; k++) begin
          serve_one(int'($urandom_range(0, 4)), a, d, got, hs);
          n_checks++; if ({got, hs, a, d} !== {2'b11, exp[k]})
            $display("FAIL rand_write%0d got=%b%b %h/%h exp=11 %h/%h", k, got, hs, a, d, exp[k].addr, exp[k].data);
          else n_pass++;
        end
      end
    join
    wait_done;
    n_checks++; if ({LOADER_DONE, ldr_overflow, LOADER_OE} !== 3'b100)
      $display("FAIL rand_end got=%b exp=100", {LOADER_DONE, ldr_overflow, LOADER_OE}); else n_pass++;
  endtask

`ifdef LDR_CHECKSUM_EN
  task automatic test_checksum;
    logic [AW-1:0] a;
    logic [7:0] d;
    logic got, hs;
    do_reset;
    ioctl_download = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) push_byte(AW'(i), 8'hFF);
    ioctl_download = 1'b0;
    for (int k = 0; k < 3; k++) serve_one(1, a, d, got, hs);
    wait_done;
    n_checks++; if (ldr_sum !== 16'h02FD) $display("FAIL checksum got=%h exp=02fd", ldr_sum); else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_drain;
    test_reset_mid;
    for (int r = 0; r < 3; r++) test_random_stream;
`ifdef LDR_CHECKSUM_EN
    test_checksum;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
